// File: rtl/mux_arb_defs.sv
// rtl/mux_arb_defs.sv - shared constants, types and rotate-priority pick for the mux arbiter
package mux_arb_defs;
   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } pick_t;

   // First set bit of req searching start, start+1, ... with modulo-8 wrap.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] start);
      pick_t            p;
      logic [SEL_W-1:0] k;
      p = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         k = start + SEL_W'(i);
         if (req[k]) begin
            p.found = 1'b1;
            p.idx   = k;
         end
      end
      return p;
   endfunction
endpackage

// File: rtl/mux_8to1.sv
// rtl/mux_8to1.sv - 8:1 single-bit multiplexer
module mux_8to1 (
   input  logic [7:0] in,
   input  logic [2:0] select,
   output logic       out
);
   assign out = in[select];
endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner of the mux_8to1 select with bounded hold time
module mux_rr_arbiter
   import mux_arb_defs::*;
#(
   parameter int HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] data_in,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] gnt,
   output logic             out_valid,
   output logic             data_out,
   output logic             busy
);
   localparam int HC_W = $clog2(HOLD_MAX) + 1;
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [0:0]       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [HC_W-1:0]  hold_q, hold_d;

   pick_t idle_pick, rel_pick;
   logic  release_now;
   logic  mux_out;

   assign idle_pick   = rr_pick(req, ptr_q);
   // Search begins just past the holder so it is the last candidate.
   assign rel_pick    = rr_pick(req, sel_q + SEL_W'(1));
   assign release_now = !req[sel_q] || (hold_q == HC_W'(HOLD_MAX - 1));

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (en && |req) begin
               state_d = ST_GRANT;
               sel_d   = idle_pick.idx;
               gnt_d   = ONE << idle_pick.idx;
               hold_d  = '0;
            end
         end
         default: begin
            if (!en) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               hold_d  = '0;
            end else if (release_now) begin
               hold_d = '0;
               if (rel_pick.found) begin
                  sel_d = rel_pick.idx;
                  gnt_d = ONE << rel_pick.idx;
                  ptr_d = rel_pick.idx + SEL_W'(1);
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
                  ptr_d   = sel_q + SEL_W'(1);
               end
            end else begin
               hold_d = hold_q + HC_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         gnt_q   <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   mux_8to1 u_mux (
      .in     (data_in),
      .select (sel_q),
      .out    (mux_out)
   );

   assign sel       = sel_q;
   assign gnt       = gnt_q;
   assign busy      = (state_q == ST_GRANT);
   assign out_valid = (|gnt_q) && req[sel_q];
   assign data_out  = out_valid && mux_out;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed vector bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [7:0] data_in;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       out_valid;
   logic       data_out;
   logic       busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       en;
      logic [7:0] req;
      logic [7:0] din;
      logic [2:0] sel;
      logic [7:0] gnt;
      logic       valid;
      logic       dout;
      logic       busy;
   } vec_t;

   vec_t tv[25];

   mux_rr_arbiter #(.HOLD_MAX(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .data_in   (data_in),
      .sel       (sel),
      .gnt       (gnt),
      .out_valid (out_valid),
      .data_out  (data_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2:0] e_sel, input logic [7:0] e_gnt,
                        input logic e_valid, input logic e_dout, input logic e_busy);
      total++;
      if (sel !== e_sel || gnt !== e_gnt || out_valid !== e_valid || data_out !== e_dout || busy !== e_busy) begin
         bad++;
         $display("FAIL %s: got sel=%0d gnt=%b valid=%b dout=%b busy=%b, want sel=%0d gnt=%b valid=%b dout=%b busy=%b",
                  name, sel, gnt, out_valid, data_out, busy, e_sel, e_gnt, e_valid, e_dout, e_busy);
      end
   endtask

   function automatic vec_t mk(input logic e, input logic [7:0] r, input logic [7:0] d, input logic [2:0] s,
                               input logic [7:0] g, input logic v, input logic o, input logic b);
      vec_t t;
      t.en = e; t.req = r; t.din = d; t.sel = s; t.gnt = g; t.valid = v; t.dout = o; t.busy = b;
      return t;
   endfunction

   initial begin
      // Idle with enable low, then single-holder grant, drop, hand-off, wrap, sole requester.
      tv[0]  = mk(1'b0, 8'hFF, 8'hFF, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      tv[1]  = mk(1'b1, 8'h04, 8'h04, 3'd2, 8'h04, 1'b1, 1'b1, 1'b1);
      tv[2]  = mk(1'b1, 8'h04, 8'hFB, 3'd2, 8'h04, 1'b1, 1'b0, 1'b1);
      tv[3]  = mk(1'b1, 8'h00, 8'hFB, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0);
      tv[4]  = mk(1'b1, 8'h08, 8'h08, 3'd3, 8'h08, 1'b1, 1'b1, 1'b1);
      tv[5]  = mk(1'b1, 8'h08, 8'h08, 3'd3, 8'h08, 1'b1, 1'b1, 1'b1);
      tv[6]  = mk(1'b1, 8'h08, 8'h08, 3'd3, 8'h08, 1'b1, 1'b1, 1'b1);
      tv[7]  = mk(1'b1, 8'h20, 8'h20, 3'd5, 8'h20, 1'b1, 1'b1, 1'b1);
      tv[8]  = mk(1'b1, 8'h80, 8'h00, 3'd7, 8'h80, 1'b1, 1'b0, 1'b1);
      tv[9]  = mk(1'b1, 8'h03, 8'h03, 3'd0, 8'h01, 1'b1, 1'b1, 1'b1);
      tv[10] = mk(1'b1, 8'h02, 8'h03, 3'd1, 8'h02, 1'b1, 1'b1, 1'b1);
      tv[11] = mk(1'b1, 8'h00, 8'h00, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 12; i < 24; i++)
         tv[i] = mk(1'b1, 8'h10, 8'h10, 3'd4, 8'h10, 1'b1, 1'b1, 1'b1);
      tv[24] = mk(1'b1, 8'h00, 8'h10, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0);

      rst_n = 1'b0; en = 1'b0; req = 8'h00; data_in = 8'h00;
      #2;
      check("reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      #6 rst_n = 1'b1;

      for (int i = 0; i < 25; i++) begin
         en = tv[i].en; req = tv[i].req; data_in = tv[i].din;
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), tv[i].sel, tv[i].gnt, tv[i].valid, tv[i].dout, tv[i].busy);
         if (i == 1) begin
            data_in = 8'hFB; #1;
            check("comb_dout", 3'd2, 8'h04, 1'b1, 1'b0, 1'b1);
         end
      end

      // Async reset mid-grant: ptr is 5 here, so first grant goes to 5.
      en = 1'b1; req = 8'hFF; data_in = 8'hFF;
      @(posedge clk); #1;
      check("pre_rst_grant", 3'd5, 8'h20, 1'b1, 1'b1, 1'b1);
      #2 rst_n = 1'b0;
      #1 check("async_rst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      #3 rst_n = 1'b1;

      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         check($sformatf("rot%0d", i), 3'((i / 4) % 8), 8'(1 << ((i / 4) % 8)), 1'b1, 1'b1, 1'b1);
      end

      en = 1'b0;
      @(posedge clk); #1;
      check("abort", 3'd1, 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("abort_idle", 3'd1, 8'h00, 1'b0, 1'b0, 1'b0);
      en = 1'b1;
      @(posedge clk); #1;
      check("after_abort", 3'd2, 8'h04, 1'b1, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
